// File: rtl/alu_pkg.sv
// Shared types and encodings for the ALU issue slice: op codes, primary opcodes,
// the decoded-entry struct and the issue FSM state type.
package alu_pkg;

    localparam logic [4:0] ALU_NOP     = 5'b00000;
    localparam logic [4:0] ALU_INC     = 5'b00010;
    localparam logic [4:0] ALU_DEC     = 5'b00011;
    localparam logic [4:0] ALU_BLT     = 5'b00100;
    localparam logic [4:0] ALU_BEQ     = 5'b01101;
    localparam logic [4:0] ALU_BEQZ    = 5'b10001;
    localparam logic [4:0] ALU_OP_LAST = 5'b10011;

    localparam logic [5:0] OPC_RTYPE = 6'd0;
    localparam logic [5:0] OPC_BEQ   = 6'd1;
    localparam logic [5:0] OPC_BEQZ  = 6'd2;
    localparam logic [5:0] OPC_BLT   = 6'd3;
    localparam logic [5:0] OPC_INC   = 6'd4;
    localparam logic [5:0] OPC_DEC   = 6'd5;

    typedef struct packed {
        logic [4:0]  op;
        logic [4:0]  shamt;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [15:0] imm;
        logic        illegal;
    } alu_entry_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } issue_state_t;

endpackage

// File: rtl/alu_decode_table.sv
// Combinational instruction decode: maps a 32-bit word onto a decoded ALU entry.
module alu_decode_table
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    output alu_entry_t  entry
);

    logic [5:0] opcode;
    logic [4:0] funct;
    logic       unused_instr_bit;

    assign opcode           = instr[31:26];
    assign funct            = instr[4:0];
    assign unused_instr_bit = instr[5];

    always_comb begin
        entry         = '0;
        entry.rd      = instr[25:21];
        entry.rs      = instr[20:16];
        entry.rt      = instr[15:11];
        entry.shamt   = instr[10:6];
        entry.imm     = instr[15:0];
        entry.op      = ALU_NOP;
        entry.illegal = 1'b0;
        case (opcode)
            OPC_RTYPE: begin
                if (funct <= ALU_OP_LAST) begin
                    entry.op = funct;
                end else begin
                    entry.illegal = 1'b1;
                end
            end
            OPC_BEQ:  entry.op = ALU_BEQ;
            OPC_BEQZ: entry.op = ALU_BEQZ;
            OPC_BLT:  entry.op = ALU_BLT;
            OPC_INC:  entry.op = ALU_INC;
            OPC_DEC:  entry.op = ALU_DEC;
            default:  entry.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// Decode-and-issue stage: two-entry in-order buffer (main + skid) between fetch and execute.
// ALU_ISSUE_ILLEGAL_TRAP_EN adds a RUN/HALT trap that stops intake after an illegal word.
//   state | meaning
//   RUN   | accepting words while the buffer has room
//   HALT  | illegal word seen; intake stopped, buffer drains, flush resumes
module alu_issue
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_op,
    output logic [4:0]  out_shamt,
    output logic [4:0]  out_rd,
    output logic [4:0]  out_rs,
    output logic [4:0]  out_rt,
    output logic [15:0] out_imm,
    output logic        out_illegal
);

    alu_entry_t dec_entry;
    alu_entry_t main_q, main_d;
    alu_entry_t skid_q, skid_d;
    logic [1:0] count_q, count_d;
    logic       in_ready_q;
    logic       run_d;
    logic       accept;
    logic       retire;

    alu_decode_table u_decode (
        .instr (in_instr),
        .entry (dec_entry)
    );

    assign out_valid = (count_q != 2'd0);
    assign accept    = in_valid && in_ready_q;
    assign retire    = out_valid && out_ready;

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    issue_state_t state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_RUN;
        end else if (state_q == ST_RUN && accept && dec_entry.illegal) begin
            state_d = ST_HALT;
        end
    end

    assign run_d       = (state_d == ST_RUN);
    assign out_illegal = main_q.illegal;
`else
    logic unused_illegal;

    assign run_d          = 1'b1;
    assign out_illegal    = 1'b0;
    assign unused_illegal = main_q.illegal;
`endif

    // Main always holds the head; skid only fills when an accept meets a stalled head.
    always_comb begin
        count_d = count_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case (count_q)
                2'd0: begin
                    if (accept) begin
                        main_d  = dec_entry;
                        count_d = 2'd1;
                    end
                end
                2'd1: begin
                    if (accept && retire) begin
                        main_d = dec_entry;
                    end else if (accept) begin
                        skid_d  = dec_entry;
                        count_d = 2'd2;
                    end else if (retire) begin
                        count_d = 2'd0;
                    end
                end
                default: begin
                    if (retire) begin
                        main_d  = skid_q;
                        count_d = 2'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= 2'd0;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= (count_d != 2'd2) && run_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_op    = main_q.op;
    assign out_shamt = main_q.shamt;
    assign out_rd    = main_q.rd;
    assign out_rs    = main_q.rs;
    assign out_rt    = main_q.rt;
    assign out_imm   = main_q.imm;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: scoreboard queue fed by a decode reference model, checked by a
// negedge monitor, plus directed scenarios and a randomized stretch.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  out_op, out_shamt, out_rd, out_rs, out_rt;
    logic [15:0] out_imm;
    logic        out_illegal;

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct {
        logic [4:0]  op;
        logic [4:0]  shamt;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [15:0] imm;
        logic        illegal;
    } exp_t;

    exp_t sb[$];
    bit   ready_exp = 1'b0;
    bit   halted = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    alu_issue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_op      (out_op),
        .out_shamt   (out_shamt),
        .out_rd      (out_rd),
        .out_rs      (out_rs),
        .out_rt      (out_rt),
        .out_imm     (out_imm),
        .out_illegal (out_illegal)
    );

    function automatic exp_t ref_decode(input logic [31:0] w);
        exp_t       e;
        logic [4:0] branch_op [1:5];
        int         opc;
        int         fn;
        bit         bad;
        branch_op = '{5'd13, 5'd17, 5'd4, 5'd2, 5'd3};
        opc     = int'(w[31:26]);
        fn      = int'(w[4:0]);
        e.rd    = w[25:21];
        e.rs    = w[20:16];
        e.rt    = w[15:11];
        e.shamt = w[10:6];
        e.imm   = w[15:0];
        e.op    = 5'd0;
        bad     = 1'b0;
        if (opc == 0) begin
            if (fn <= 19) e.op = w[4:0];
            else bad = 1'b1;
        end else if (opc <= 5) begin
            e.op = branch_op[opc];
        end else begin
            bad = 1'b1;
        end
        e.illegal = TRAP && bad;
        return e;
    endfunction

    function automatic logic [31:0] mk(input int opc, input int fn);
        logic [31:0] w;
        w        = $urandom();
        w[31:26] = 6'(opc);
        w[4:0]   = 5'(fn);
        return w;
    endfunction

    function automatic logic [31:0] rand_legal();
        int opc;
        opc = $urandom_range(0, 5);
        return mk(opc, $urandom_range(0, 19));
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send(input logic [31:0] w, output int cyc, output bit ok);
        bit r;
        ok = 1'b0;
        cyc = 0;
        in_valid = 1'b1;
        in_instr = w;
        while (!ok && cyc < 20) begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (r) ok = 1'b1;
        end
        in_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout: word %h not accepted in %0d cycles", w, cyc);
        end
    endtask

    // Reference model: tracks accepted words and the trap, at the clock edge.
    always @(posedge clk) begin : model
        exp_t e;
        if (rst_n) begin
            if (flush) begin
                sb.delete();
                halted = 1'b0;
                ready_exp = 1'b1;
            end else begin
                if (in_valid && ready_exp) begin
                    e = ref_decode(in_instr);
                    sb.push_back(e);
                    if (TRAP && e.illegal) halted = 1'b1;
                end
                ready_exp = (sb.size() < 2) && !halted;
            end
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            chk("in_ready", in_ready, ready_exp);
            chk("out_valid", out_valid, sb.size() != 0);
            if (sb.size() != 0) begin
                e = sb[0];
                chk("entry", {out_op, out_shamt, out_rd, out_rs, out_rt, out_imm, out_illegal},
                    {e.op, e.shamt, e.rd, e.rs, e.rt, e.imm, e.illegal});
                if (out_ready && !flush) void'(sb.pop_front());
            end
        end
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        sb.delete();
        ready_exp = 1'b0;
        halted = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_data", {out_op, out_shamt, out_rd, out_rs, out_rt, out_imm, out_illegal}, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", in_ready, 0);
        @(posedge clk);
        #1;
        chk("ready_after_edge", in_ready, 1);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [31:0] w;
        int          cyc;
        bit          ok;

        #3;
        apply_reset();

        // single R-type word, one-cycle latency then empty
        out_ready = 1'b1;
        w = mk(0, 7);
        w[10:6] = 5'd3;
        send(w, cyc, ok);
        chk("r031_valid", out_valid, 1);
        chk("r031_op", out_op, 5'b00111);
        chk("r031_shamt", out_shamt, 5'd3);
        @(posedge clk);
        #1;
        chk("r031_drain", out_valid, 0);

        // three words against a stalled consumer
        out_ready = 1'b0;
        send(rand_legal(), cyc, ok);
        send(rand_legal(), cyc, ok);
        in_valid = 1'b1;
        in_instr = rand_legal();
        repeat (3) begin
            @(negedge clk);
            chk("r032_full_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(in_instr, cyc, ok);
        repeat (4) @(posedge clk);
        #1;
        chk("r032_drained", out_valid, 0);

        // streaming at occupancy 1
        out_ready = 1'b0;
        send(rand_legal(), cyc, ok);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(rand_legal(), cyc, ok);
            chk("r033_cycles", cyc, 1);
        end
        chk("r033_occ", out_valid, 1);
        repeat (3) @(posedge clk);
        #1;

        // illegal opcode
        w = mk(63, $urandom_range(0, 31));
        send(w, cyc, ok);
        chk("r034_illegal", out_illegal, TRAP);
        chk("r034_op", out_op, 0);
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("r034_halt_ready", in_ready, 0);
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("r034_resume", in_ready, 1);
`else
        send(rand_legal(), cyc, ok);
        chk("r034_continue", cyc, 1);
`endif
        repeat (3) @(posedge clk);
        #1;

        // flush against full buffer with a pending word, then against a same-cycle accept
        out_ready = 1'b0;
        send(rand_legal(), cyc, ok);
        send(rand_legal(), cyc, ok);
        flush = 1'b1;
        in_valid = 1'b1;
        in_instr = rand_legal();
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        chk("r035_full_valid", out_valid, 0);
        chk("r035_full_ready", in_ready, 1);
        send(rand_legal(), cyc, ok);
        flush = 1'b1;
        in_valid = 1'b1;
        in_instr = rand_legal();
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        chk("r035_acc_valid", out_valid, 0);
        chk("r035_acc_ready", in_ready, 1);
        @(posedge clk);
        #1;
        chk("r035_discarded", out_valid, 0);

        // asynchronous reset mid-cycle while full
        send(rand_legal(), cyc, ok);
        send(rand_legal(), cyc, ok);
        chk("r036_full", out_valid, 1);
        #2;
        apply_reset();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            w = $urandom();
            if ($urandom_range(0, 3) != 0) w[31:26] = 6'($urandom_range(0, 5));
            in_instr  = w;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("final_empty", out_valid, 0);
        chk("final_sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
